// File: rtl/sdram_arb2.sv
// sdram_arb2 -- two-master arbiter in front of the SDRAM controller's
// valid/ready port. It serialises word requests from m0 (CPU) and m1
// (DMA/video) onto the single controller port, one transaction at a time.
// It also routes the read data and the completion pulse back to the owning
// master only.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   mN_addr/din/wmask    : master request (wmask == 0 means read)
//   mN_valid             : master request, held until mN_ready
//   mN_dout, mN_ready    : read data / one-cycle completion pulse
//   mem_addr/din/wmask   : registered request to the controller
//   mem_valid            : registered request strobe to the controller
//   mem_dout, mem_ready  : controller read data / one-cycle completion pulse
//   grant                : owner of the current or last transaction (debug)
//
// Build option
//   SDRAM_ARB_RR_EN      : defined -> round-robin on ties,
//                          undefined -> fixed priority (m0 wins ties)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction open; arbitrate and latch the winner's request
// ISSUE | mem_valid high, request frozen, waiting for mem_ready
// DONE  | winner's ready pulse; mem_valid low so the request is not re-seen

module sdram_arb2 #(
  parameter int ADDR_WIDTH = 25
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_din,
  input  logic [3:0]            m0_wmask,
  input  logic                  m0_valid,
  output logic [31:0]           m0_dout,
  output logic                  m0_ready,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_din,
  input  logic [3:0]            m1_wmask,
  input  logic                  m1_valid,
  output logic [31:0]           m1_dout,
  output logic                  m1_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic [3:0]            mem_wmask,
  output logic                  mem_valid,
  input  logic [31:0]           mem_dout,
  input  logic                  mem_ready,
  output logic                  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  logic   any_valid;
  logic   pick_m1;

  // Winner selection; only used in IDLE when any_valid is set.
  always_comb begin
    any_valid = m0_valid | m1_valid;
`ifdef SDRAM_ARB_RR_EN
    // On a tie, hand the port to whoever did not own it last.
    if (m0_valid && m1_valid) pick_m1 = ~grant;
    else                      pick_m1 = m1_valid;
`else
    pick_m1 = ~m0_valid;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_wmask <= '0;
      mem_valid <= 1'b0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
      m0_dout   <= '0;
      m1_dout   <= '0;
      // Starting at 1 means m0 wins the first tie under round-robin.
      grant     <= 1'b1;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant     <= pick_m1;
            mem_addr  <= pick_m1 ? m1_addr  : m0_addr;
            mem_din   <= pick_m1 ? m1_din   : m0_din;
            mem_wmask <= pick_m1 ? m1_wmask : m0_wmask;
            mem_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= DONE;
            // Writes leave the owner's read-data register untouched.
            if (grant) begin
              m1_ready <= 1'b1;
              if (mem_wmask == 4'd0) m1_dout <= mem_dout;
            end else begin
              m0_ready <= 1'b1;
              if (mem_wmask == 4'd0) m0_dout <= mem_dout;
            end
          end
        end
        DONE: begin
          // The winner's valid is still high here, so no arbitration.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb2.sv
module tb_sdram_arb2;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0]   m0_din = '0, m1_din = '0;
  logic [3:0]    m0_wmask = '0, m1_wmask = '0;
  logic          m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0]   m0_dout, m1_dout;
  logic          m0_ready, m1_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic [3:0]    mem_wmask;
  logic          mem_valid;
  logic [31:0]   mem_dout;
  logic          mem_ready;
  logic          grant;

  // Controller model state
  logic          mdl_en = 1'b1;
  logic          mdl_ready = 1'b0;
  logic [31:0]   mdl_dout = '0;
  logic          man_ready = 1'b0;
  logic [31:0]   man_dout = '0;
  logic          rnd_mode = 1'b0;
  int            lat = 1;
  logic [31:0]   resp_data = '0;
  logic [31:0]   last_dout = '0;
  logic          busy = 1'b0;
  int            cnt = 0;
  int            txn_cnt = 0;
  logic          txn_grant [0:255];

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp0 = '0, exp1 = '0;

  assign mem_ready = mdl_en ? mdl_ready : man_ready;
  assign mem_dout  = mdl_en ? mdl_dout  : man_dout;

  always #5 clk = ~clk;

  sdram_arb2 #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_din(m0_din), .m0_wmask(m0_wmask), .m0_valid(m0_valid),
    .m0_dout(m0_dout), .m0_ready(m0_ready),
    .m1_addr(m1_addr), .m1_din(m1_din), .m1_wmask(m1_wmask), .m1_valid(m1_valid),
    .m1_dout(m1_dout), .m1_ready(m1_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wmask(mem_wmask),
    .mem_valid(mem_valid), .mem_dout(mem_dout), .mem_ready(mem_ready),
    .grant(grant)
  );

  // Controller model: accepts a request when it sees mem_valid while idle,
  // answers lat+1 cycles later with a one-cycle ready pulse. Any valid seen
  // after the pulse counts as a new transaction.
  always @(posedge clk) begin
    #2;
    mdl_ready = 1'b0;
    if (!resetn) begin
      busy = 1'b0;
    end else if (busy) begin
      if (cnt == 0) begin
        mdl_ready = 1'b1;
        mdl_dout  = rnd_mode ? $urandom : resp_data;
        last_dout = mdl_dout;
        busy      = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end else if (mdl_en && mem_valid) begin
      busy = 1'b1;
      cnt  = rnd_mode ? int'($urandom_range(0, 4)) : lat;
      if (txn_cnt < 256) txn_grant[txn_cnt] = grant;
      txn_cnt = txn_cnt + 1;
    end
  end

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %0b want 0", mem_valid); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL reset_mem_din got %h want 0", mem_din); end
    checks++; if (mem_wmask !== 4'h0) begin errors++; $display("FAIL reset_mem_wmask got %h want 0", mem_wmask); end
    checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {m0_ready, m1_ready}); end
    checks++; if (m0_dout !== 32'h0 || m1_dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h/%h want 0/0", m0_dout, m1_dout); end
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL reset_grant got %0b want 1", grant); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    bit seen;
    @(negedge clk);
    mdl_en = 1'b1; rnd_mode = 1'b0; lat = 1; resp_data = 32'hDEADBEEF;
    m0_addr = 25'h0000100; m0_din = 32'h0; m0_wmask = 4'h0; m0_valid = 1'b1;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL read_issue_valid got %0b want 1", mem_valid); end
    checks++; if (mem_addr !== 25'h0000100) begin errors++; $display("FAIL read_issue_addr got %h want 0000100", mem_addr); end
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL read_grant got %0b want 0", grant); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_ready) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL read_mem_ready_timeout got 0 want 1"); end
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL read_early_ready got %0b want 0", m0_ready); end
    @(negedge clk);
    checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL read_m0_ready got %0b want 1", m0_ready); end
    checks++; if (m0_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL read_m0_dout got %h want deadbeef", m0_dout); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop got %0b want 0", mem_valid); end
    checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL read_m1_ready got %0b want 0", m1_ready); end
    exp0 = 32'hDEADBEEF;
    m0_valid = 1'b0;
    @(negedge clk);
    checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL read_ready_width got %0b want 0", m0_ready); end
    checks++; if (m0_dout !== exp0) begin errors++; $display("FAIL read_dout_hold got %h want %h", m0_dout, exp0); end
  endtask

  task automatic test_m1_write();
    bit seen;
    @(negedge clk);
    lat = 3; resp_data = 32'hCAFEF00D;
    m1_addr = 25'h1ABCDE0; m1_din = 32'h12345678; m1_wmask = 4'b0011; m1_valid = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL write_grant got %0b want 1", grant); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      checks++;
      if (mem_valid !== 1'b1 || mem_din !== 32'h12345678 || mem_wmask !== 4'b0011 || mem_addr !== 25'h1ABCDE0) begin
        errors++;
        $display("FAIL write_hold got v=%0b din=%h wm=%b a=%h want 1 12345678 0011 1abcde0", mem_valid, mem_din, mem_wmask, mem_addr);
      end
      if (mem_ready) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL write_mem_ready_timeout got 0 want 1"); end
    @(negedge clk);
    checks++; if (m1_ready !== 1'b1) begin errors++; $display("FAIL write_m1_ready got %0b want 1", m1_ready); end
    checks++; if (m1_dout !== exp1) begin errors++; $display("FAIL write_m1_dout got %h want %h", m1_dout, exp1); end
    checks++; if (m0_ready !== 1'b0 || m0_dout !== exp0) begin errors++; $display("FAIL write_m0_side got %0b/%h want 0/%h", m0_ready, m0_dout, exp0); end
    m1_valid = 1'b0;
  endtask

  task automatic test_stray_ready();
    @(negedge clk);
    @(negedge clk);
    mdl_en = 1'b0;
    man_dout = 32'hFFFF0000; man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || mem_valid !== 1'b0 || m0_dout !== exp0 || m1_dout !== exp1) begin
        errors++;
        $display("FAIL stray_ready got r=%b v=%0b d0=%h d1=%h want 00 0 %h %h", {m0_ready, m1_ready}, mem_valid, m0_dout, m1_dout, exp0, exp1);
      end
      @(negedge clk);
    end
    mdl_en = 1'b1;
  endtask

  task automatic test_arbitration();
    int r0, r1, d0, d1, base;
    logic exp_g [0:4];
`ifdef SDRAM_ARB_RR_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
    lat = 0; rnd_mode = 1'b0; resp_data = 32'h0BADF00D;
    r0 = 3; r1 = 2; d0 = 0; d1 = 0;
    base = txn_cnt;
    for (int c = 0; c < 200 && (d0 < 3 || d1 < 2); c++) begin
      @(negedge clk);
      if (m0_ready) begin d0++; m0_valid = 1'b0; end
      if (m1_ready) begin d1++; m1_valid = 1'b0; end
      if (!m0_valid && r0 > 0) begin r0--; m0_addr = 25'h0000200; m0_wmask = 4'h0; m0_valid = 1'b1; end
      if (!m1_valid && r1 > 0) begin r1--; m1_addr = 25'h0000300; m1_wmask = 4'h0; m1_valid = 1'b1; end
    end
    checks++; if (d0 !== 3 || d1 !== 2) begin errors++; $display("FAIL arb_done got %0d/%0d want 3/2", d0, d1); end
    checks++; if (txn_cnt - base !== 5) begin errors++; $display("FAIL arb_txn_count got %0d want 5", txn_cnt - base); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (txn_grant[base + i] !== exp_g[i]) begin
        errors++; $display("FAIL arb_grant_seq[%0d] got m%0d want m%0d", i, txn_grant[base + i], exp_g[i]);
      end
    end
    exp0 = 32'h0BADF00D; exp1 = 32'h0BADF00D;
  endtask

  task automatic test_reset_mid_issue();
    bit seen;
    @(negedge clk);
    lat = 10; rnd_mode = 1'b0;
    m0_addr = 25'h0000040; m0_wmask = 4'h0; m0_valid = 1'b1;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_valid got %0b want 1", mem_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_clear got v=%0b r=%b want 0 00", mem_valid, {m0_ready, m1_ready}); end
    checks++; if (m0_dout !== 32'h0 || grant !== 1'b1) begin errors++; $display("FAIL rst_mid_state got d0=%h g=%0b want 0 1", m0_dout, grant); end
    exp0 = 32'h0; exp1 = 32'h0;
    m0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    lat = 1; resp_data = 32'hA5A50001;
    m0_addr = 25'h0000044; m0_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m0_ready) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_mid_after_timeout got 0 want 1"); end
    checks++; if (m0_dout !== 32'hA5A50001) begin errors++; $display("FAIL rst_mid_after_dout got %h want a5a50001", m0_dout); end
    exp0 = 32'hA5A50001;
    m0_valid = 1'b0;
  endtask

  task automatic test_random();
    int r0, r1, d0, d1, base;
    rnd_mode = 1'b1;
    r0 = 50; r1 = 50; d0 = 0; d1 = 0;
    base = txn_cnt;
    for (int c = 0; c < 5000 && (d0 < 50 || d1 < 50); c++) begin
      @(negedge clk);
      if (m0_ready && m1_ready) begin
        checks++; errors++; $display("FAIL rand_both_ready got 11 want one-hot");
      end
      if (m0_ready) begin
        d0++;
        if (m0_wmask == 4'h0) exp0 = last_dout;
        checks++; if (m0_dout !== exp0) begin errors++; $display("FAIL rand_m0_dout got %h want %h", m0_dout, exp0); end
        m0_valid = 1'b0;
      end
      if (m1_ready) begin
        d1++;
        if (m1_wmask == 4'h0) exp1 = last_dout;
        checks++; if (m1_dout !== exp1) begin errors++; $display("FAIL rand_m1_dout got %h want %h", m1_dout, exp1); end
        m1_valid = 1'b0;
      end
      if (!m0_valid && r0 > 0 && $urandom_range(0, 1) == 1) begin
        r0--; m0_addr = AW'($urandom); m0_din = $urandom;
        m0_wmask = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        m0_valid = 1'b1;
      end
      if (!m1_valid && r1 > 0 && $urandom_range(0, 1) == 1) begin
        r1--; m1_addr = AW'($urandom); m1_din = $urandom;
        m1_wmask = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
        m1_valid = 1'b1;
      end
    end
    checks++; if (d0 !== 50 || d1 !== 50) begin errors++; $display("FAIL rand_done got %0d/%0d want 50/50", d0, d1); end
    checks++; if (txn_cnt - base !== 100) begin errors++; $display("FAIL rand_txn_count got %0d want 100", txn_cnt - base); end
    rnd_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_m1_write();
    test_stray_ready();
    test_arbitration();
    test_reset_mid_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arb2.md
# sdram_arb2

Two-master arbiter directly upstream of the SDRAM controller's valid/ready port. It accepts word requests from master 0 (CPU) and master 1 (DMA/video) and serialises them onto the single controller port, one transaction at a time. It registers the winning request and returns the controller's read data and completion pulse to the owning master only. It also guarantees the controller sees `valid` low on the cycle after its `ready` pulse, so no request is re-issued.

## Interface
- `ADDR_WIDTH`, 25: byte-address width forwarded to the controller.
- `clk` input 1: single clock, shared with the controller.
- `resetn` input 1: asynchronous, active-low reset.
- `m0_addr` / `m1_addr` input ADDR_WIDTH: master request address.
- `m0_din` / `m1_din` input 32: write data.
- `m0_wmask` / `m1_wmask` input 4: byte write enables; 0 means read.
- `m0_valid` / `m1_valid` input 1: request; held until the matching ready.
- `m0_dout` / `m1_dout` output 32: read data, valid when the matching ready is 1.
- `m0_ready` / `m1_ready` output 1: one-cycle completion pulse.
- `mem_addr` output ADDR_WIDTH: to controller `addr`.
- `mem_din` output 32: to controller `din`.
- `mem_wmask` output 4: to controller `wmask`.
- `mem_valid` output 1: to controller `valid`.
- `mem_dout` input 32: from controller `dout`.
- `mem_ready` input 1: from controller `ready`, a one-cycle pulse.
- `grant` output 1: owner of the current or last transaction (0 = m0, 1 = m1). Debug only.

## Operation
- Reset state (async, `resetn`=0):
  - state = IDLE.
  - all `mem_*` outputs are 0.
  - `m0_ready` = `m1_ready` = 0.
  - `m0_dout` = `m1_dout` = 0.
  - `grant` = 1, so with round robin enabled m0 wins the first tie.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - If no `mN_valid` is high, stay in IDLE.
  - Otherwise pick a winner, latch its `addr`, `din` and `wmask` into the `mem_*` registers, set `grant`, set `mem_valid`=1, and go to ISSUE.
- ISSUE:
  - Hold all `mem_*` registers stable.
  - Ignore master inputs; a master changing its inputs while unserved is a protocol violation and is not checked.
  - On `mem_ready`=1: capture `mem_dout` into the winner's `dout`, clear `mem_valid`, pulse the winner's ready next cycle, and go to DONE.
- DONE:
  - The winner's `mN_ready` is 1 for exactly this cycle; `mem_valid` = 0.
  - Always go to IDLE.
  - Do not arbitrate in DONE: the winner's `valid` is still high this cycle and must not be re-granted.
- Arbitration policy is set by `SDRAM_ARB_RR_EN` (see Configuration).
- `mN_dout` holds its value until that master's next read completes. Writes leave `mN_dout` unchanged.
- The loser's ready is never asserted, and its `dout` is unchanged.
- A `mem_ready` pulse outside ISSUE is ignored.
- Reset asserted mid-transaction: all state clears immediately. The controller shares `resetn`, so no transaction is orphaned.

## Timing
- Grant latency: a request present in IDLE at edge N gives `mem_valid`=1 after edge N.
- Completion: `mem_ready` high in cycle C gives `mN_ready`=1 and `mN_dout` valid in cycle C+1.
- Total overhead is 2 cycles over the controller latency (issue register + return register).
- `mem_valid` falls in the same cycle that `mN_ready` rises, i.e. before the controller returns to its idle check.
- Back-to-back:
  - The earliest re-grant is the IDLE cycle after DONE.
  - With both masters continuously requesting, consecutive grants are at least 3 cycles plus the controller latency apart.
- All outputs are registered; there is no combinational path from `mem_*` inputs to master outputs.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round robin.
  - On a tie, grant the master other than `grant`.
  - A single requester always wins.
- `SDRAM_ARB_RR_EN` undefined: fixed priority. m0 always wins a tie, and m1 can starve. `grant` still reflects the last owner.

## Test plan
- Single m0 read:
  - Stimulus: `m0_addr`=0x0000100, `wmask`=0; the model returns `mem_dout`=0xDEADBEEF with `mem_ready`.
  - Required: `mem_addr`=0x0000100 one cycle after request; `m0_ready` one cycle after `mem_ready`; `m0_dout`=0xDEADBEEF; `m1_ready` stays 0.
- m1 write:
  - Stimulus: `m1_din`=0x12345678, `m1_wmask`=4'b0011.
  - Required: `mem_wmask`=4'b0011 and `mem_din`=0x12345678 held stable until `mem_ready`; `m1_dout` unchanged.
- Simultaneous requests, continuously held, `SDRAM_ARB_RR_EN` defined:
  - Required: grant sequence m0, m1, m0, m1. Undefined: m0, m0, m0.
- Valid-drop check:
  - Stimulus: the model asserts `mem_ready` for 1 cycle.
  - Required: `mem_valid`=0 on the next cycle; the model sees exactly one transaction per request (transaction count = request count over 100 random requests).
- Reset mid-ISSUE:
  - Stimulus: deassert `resetn` asynchronously between clock edges while `mem_valid`=1.
  - Required: `mem_valid`, `m0_ready` and `m1_ready` go to 0 immediately; after release, a fresh m0 request completes normally.
- Stray `mem_ready` in IDLE:
  - Required: no `mN_ready` pulse and no `dout` change.
